seg7_scan_capture: RTL and testbench
====================================

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive identical input cycles required before a capture (legal range 2..255).
REQ-003 Port CLOCK_50 input 1 SHALL be the sole clock; all state updates on its rising edge.
REQ-004 Port reset input 1 SHALL be the asynchronous active-high reset.
REQ-005 Port seg_in input 7 SHALL carry active-low segment lines, bit 6 = g down to bit 0 = a.
REQ-006 Port digit_sel input 6 SHALL carry the active-high digit strobe, one-hot, where bit i selects digit i and digit 0 is least significant.
REQ-007 Port frame_ready input 1 SHALL be the consumer acceptance of frame_value.
REQ-008 Port err_clr input 1 SHALL clear err_illegal.
REQ-009 Port frame_value output 24 SHALL hold the last completed frame, with digit i in bits 4i+3:4i.
REQ-010 Port frame_valid output 1 SHALL indicate that frame_value holds an unaccepted frame.
REQ-011 Port digit_valid output 6 SHALL flag each digit whose last capture decoded to a legal glyph.
REQ-012 Port overrun output 1 SHALL be sticky and indicate that a frame was overwritten before acceptance.
REQ-013 Port err_illegal output 1 SHALL be sticky and indicate that an illegal, non-blank pattern was captured.

Function
REQ-014 The decode table SHALL map the patterns below to the listed nibble:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0011000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-015 The pattern 1111111 SHALL be treated as blank; any other unlisted pattern SHALL be treated as illegal.
REQ-016 Scan FSM states SHALL be IDLE, SETTLE and HELD.
REQ-017 From IDLE, a one-hot digit_sel SHALL cause a transition to SETTLE, load the stability counter with 1, and register {seg_in, digit_sel}.
REQ-018 In SETTLE, if inputs equal the registered value, the counter SHALL increment; on reaching STABLE_CYCLES the block SHALL capture and go to HELD on the same edge.
REQ-019 In SETTLE, changed inputs that are still one-hot SHALL re-register, set the counter to 1 and remain in SETTLE; non-one-hot inputs (zero or multiple bits) SHALL return the FSM to IDLE.
REQ-020 HELD SHALL perform no further captures while the inputs are unchanged; any change SHALL be handled as in REQ-019.
REQ-021 A capture of a legal pattern for digit i SHALL write the nibble into the working register, set digit_valid[i] and set seen[i].
REQ-022 A capture of a blank or illegal pattern SHALL clear digit_valid[i], leave the working nibble unchanged and set seen[i]; an illegal pattern SHALL additionally set err_illegal.
REQ-023 When seen reaches 6'b111111, on the edge after the completing capture, the block SHALL copy the working register to frame_value, set frame_valid and clear seen.
REQ-024 A frame is accepted when frame_valid=1 and frame_ready=1 on an edge; acceptance SHALL clear frame_valid unless a frame load occurs on the same edge, in which case frame_valid stays 1 and overrun is not set.
REQ-025 A frame load while frame_valid=1 and frame_ready=0 SHALL overwrite frame_value and set overrun.
REQ-026 Capture-to-frame_valid latency SHALL be exactly 1 cycle after the sixth distinct digit capture.
REQ-027 Repeated captures of an already-seen digit SHALL update that nibble and SHALL NOT complete a frame.
REQ-028 err_clr SHALL clear err_illegal and overrun; a set event coinciding with err_clr SHALL take priority and leave the flag set.

Reset
REQ-029 Reset SHALL force: FSM=IDLE, counter=0, seen=0, working register=0, frame_value=24'h000000, frame_valid=0, digit_valid=6'b000000, overrun=0, err_illegal=0.
REQ-030 Reset asserted mid-capture or mid-frame SHALL discard all partial state with no frame output.

Configuration
REQ-031 Macro SEG7_CAPTURE_ERR_EN defined SHALL compile in the err_illegal and overrun flag logic per REQ-022/025/028.
REQ-032 Without SEG7_CAPTURE_ERR_EN, err_illegal and overrun SHALL be tied 0, err_clr SHALL be ignored, and all other behaviour SHALL be identical.

Verification
REQ-033 Scan 0x3A7F1C, each digit held 8 cycles, frame_ready=1 -> frame_valid pulses 1 cycle, frame_value=24'h3A7F1C, digit_valid=6'h3F.
REQ-034 Glitch: digit 2 pattern held 3 cycles then changed (STABLE_CYCLES=4) -> no capture for the glitch and seen[2] stays 0.
REQ-035 digit_sel=6'b000011 for 10 cycles -> FSM stays in IDLE with no capture.
REQ-036 Digit 4 = 1010101 (illegal), digit 5 = 1111111 -> digit_valid=6'b001111, err_illegal=1, frame still completes; with macro undefined, err_illegal=0.
REQ-037 Two frames with frame_ready=0 -> second frame_value visible and overrun=1; err_clr pulse -> overrun=0.
REQ-038 Reset pulsed after 3 digit captures, then a full scan of 0x000123 -> single frame 24'h000123, no stale nibbles.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture
//
// Purpose:
//    Watches the segment and digit-strobe lines of a multiplexed, six-digit,
//    seven-segment display. It waits for the lines to settle, decodes each
//    settled glyph back into a hex nibble, and rebuilds the 24-bit value
//    being shown. Once every digit position has been captured, the completed
//    frame is handed to a consumer using a valid/ready acceptance.
//
// Parameters:
//    STABLE_CYCLES  consecutive identical input cycles needed before a
//                   capture (legal range 2..255, default 4)
//
// Ports:
//    CLOCK_50     in   sole clock, rising edge
//    reset        in   asynchronous active-high reset
//    seg_in       in   [6:0] active-low segment lines, bit 6 = g .. bit 0 = a
//    digit_sel    in   [5:0] active-high one-hot digit strobe, bit 0 = LS digit
//    frame_ready  in   consumer accepts frame_value
//    err_clr      in   clears the sticky err_illegal / overrun flags
//    frame_value  out  [23:0] last completed frame, digit i in bits 4i+3:4i
//    frame_valid  out  frame_value holds a frame not yet accepted
//    digit_valid  out  [5:0] digit i last decoded to a legal glyph
//    overrun      out  sticky: a frame was overwritten before acceptance
//    err_illegal  out  sticky: an illegal, non-blank pattern was captured
//
// Configuration:
//    SEG7_CAPTURE_ERR_EN  when defined, builds the err_illegal and overrun
//                         flag logic. When undefined, both flags are tied
//                         to 0 and err_clr is ignored.
// ---------------------------------------------------------------------------
module seg7_scan_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [6:0]  seg_in,
   input  logic [5:0]  digit_sel,
   input  logic        frame_ready,
   input  logic        err_clr,
   output logic [23:0] frame_value,
   output logic        frame_valid,
   output logic [5:0]  digit_valid,
   output logic        overrun,
   output logic        err_illegal
);

   localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD
   } scan_state_t;

   scan_state_t state;
   logic [7:0]  stable_cnt;
   logic [6:0]  held_seg;
   logic [5:0]  held_sel;
   logic [5:0]  seen;
   logic [23:0] work;

   logic        sel_onehot;
   logic        inputs_same;
   logic        cnt_hit;
   logic        capture;
   logic        frame_load;
   logic [3:0]  dec_nibble;
   logic        dec_legal;
   logic        dec_blank;

   // Qualify the current inputs. A strobe counts only when exactly one digit
   // is selected. "Same" compares the live lines with the snapshot taken at
   // the start of the current settle period.
   always_comb begin
      sel_onehot  = (digit_sel != 6'd0) && ((digit_sel & (digit_sel - 6'd1)) == 6'd0);
      inputs_same = ({seg_in, digit_sel} == {held_seg, held_sel});
      cnt_hit     = ((stable_cnt + 8'd1) == STABLE_TARGET);
      capture     = (state == SETTLE) && inputs_same && cnt_hit;
      frame_load  = (seen == 6'h3F);
   end

   // Map the settled glyph back to a nibble. All lines high means the digit
   // is dark (blank). Any other unlisted pattern is illegal. The snapshot is
   // decoded because it equals the live lines whenever a capture fires.
   always_comb begin
      dec_nibble = 4'h0;
      dec_legal  = 1'b1;
      dec_blank  = 1'b0;
      case (held_seg)
         7'b1000000: dec_nibble = 4'h0;
         7'b1111001: dec_nibble = 4'h1;
         7'b0100100: dec_nibble = 4'h2;
         7'b0110000: dec_nibble = 4'h3;
         7'b0011001: dec_nibble = 4'h4;
         7'b0010010: dec_nibble = 4'h5;
         7'b0000010: dec_nibble = 4'h6;
         7'b1111000: dec_nibble = 4'h7;
         7'b0000000: dec_nibble = 4'h8;
         7'b0011000: dec_nibble = 4'h9;
         7'b0001000: dec_nibble = 4'hA;
         7'b0000011: dec_nibble = 4'hB;
         7'b1000110: dec_nibble = 4'hC;
         7'b0100001: dec_nibble = 4'hD;
         7'b0000110: dec_nibble = 4'hE;
         7'b0001110: dec_nibble = 4'hF;
         7'b1111111: begin
            dec_legal = 1'b0;
            dec_blank = 1'b1;
         end
         default:    dec_legal = 1'b0;
      endcase
   end

   // Scan FSM. IDLE waits for a one-hot strobe. SETTLE counts identical
   // cycles and captures when the count reaches STABLE_CYCLES. HELD blocks
   // repeat captures of an unchanged digit. Any change of lines in SETTLE or
   // HELD restarts settling when the strobe is still one-hot, and drops back
   // to IDLE otherwise.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         stable_cnt <= 8'd0;
         held_seg   <= 7'd0;
         held_sel   <= 6'd0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_onehot) begin
                  state      <= SETTLE;
                  stable_cnt <= 8'd1;
                  held_seg   <= seg_in;
                  held_sel   <= digit_sel;
               end
            end
            SETTLE, HELD: begin
               if (inputs_same) begin
                  if (state == SETTLE) begin
                     stable_cnt <= stable_cnt + 8'd1;
                     if (cnt_hit) begin
                        state <= HELD;
                     end
                  end
               end else if (sel_onehot) begin
                  state      <= SETTLE;
                  stable_cnt <= 8'd1;
                  held_seg   <= seg_in;
                  held_sel   <= digit_sel;
               end else begin
                  state      <= IDLE;
                  stable_cnt <= 8'd0;
               end
            end
            default: begin
               state      <= IDLE;
               stable_cnt <= 8'd0;
            end
         endcase
      end
   end

   // Capture datapath and frame hand-off. A legal capture updates that
   // digit's nibble in the working register. A blank or illegal capture
   // leaves the nibble alone but still counts the digit as seen. The frame
   // is published on the edge after the sixth distinct digit is seen. No new
   // capture can land on that edge, because a capture is always followed by
   // at least one settling cycle.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         work        <= 24'h000000;
         digit_valid <= 6'b000000;
         seen        <= 6'b000000;
         frame_value <= 24'h000000;
         frame_valid <= 1'b0;
      end else begin
         if (capture) begin
            for (int i = 0; i < 6; i++) begin
               if (held_sel[i]) begin
                  digit_valid[i] <= dec_legal;
                  if (dec_legal) begin
                     work[4*i +: 4] <= dec_nibble;
                  end
               end
            end
         end

         seen <= (frame_load ? 6'b000000 : seen) | (capture ? held_sel : 6'b000000);

         // A load on the same edge as acceptance keeps frame_valid high.
         if (frame_load) begin
            frame_value <= work;
            frame_valid <= 1'b1;
         end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
         end
      end
   end

`ifdef SEG7_CAPTURE_ERR_EN
   // Sticky error flags. A new set event wins over err_clr on the same edge.
   // Overrun means a load replaced a frame that was still unaccepted.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         err_illegal <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (capture && !dec_legal && !dec_blank) begin
            err_illegal <= 1'b1;
         end else if (err_clr) begin
            err_illegal <= 1'b0;
         end

         if (frame_load && frame_valid && !frame_ready) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end
      end
   end
`else
   logic unused_err_inputs;

   assign err_illegal       = 1'b0;
   assign overrun           = 1'b0;
   assign unused_err_inputs = err_clr ^ dec_blank;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_capture
//
// Purpose:
//    Directed testbench for seg7_scan_capture with the default
//    STABLE_CYCLES = 4. It drives glyphs from a hand-written segment table
//    and compares the outputs with hand-computed values. The expected error
//    flags follow SEG7_CAPTURE_ERR_EN.
// ---------------------------------------------------------------------------
module tb_seg7_scan_capture;

`ifdef SEG7_CAPTURE_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   // Active-low glyphs for 0..F, bit 6 = g down to bit 0 = a.
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam logic [6:0] BLANK   = 7'b1111111;
   localparam logic [6:0] ILLEGAL = 7'b1010101;

   logic        CLOCK_50;
   logic        reset;
   logic [6:0]  seg_in;
   logic [5:0]  digit_sel;
   logic        frame_ready;
   logic        err_clr;
   logic [23:0] frame_value;
   logic        frame_valid;
   logic [5:0]  digit_valid;
   logic        overrun;
   logic        err_illegal;

   int          total;
   int          bad;
   int          valid_count;
   logic [23:0] last_frame;

   seg7_scan_capture dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .seg_in      (seg_in),
      .digit_sel   (digit_sel),
      .frame_ready (frame_ready),
      .err_clr     (err_clr),
      .frame_value (frame_value),
      .frame_valid (frame_valid),
      .digit_valid (digit_valid),
      .overrun     (overrun),
      .err_illegal (err_illegal)
   );

   // 10 ns clock. The bench drives and checks 2 ns after each rising edge.
   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // Count the cycles in which frame_valid is high, and keep the frame shown
   // in those cycles. The sample is taken on the falling edge, away from the
   // bench's own activity.
   always @(negedge CLOCK_50) begin
      if (frame_valid) begin
         valid_count = valid_count + 1;
         last_frame  = frame_value;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #2;
      end
   endtask

   // Present one set of segment and strobe lines for a number of cycles.
   task automatic applyStimulus(input logic [6:0] seg, input logic [5:0] sel, input int cycles);
      seg_in    = seg;
      digit_sel = sel;
      waitCycles(cycles);
   endtask

   task automatic scanDigit(input int idx, input logic [3:0] nibble);
      applyStimulus(GLYPH[nibble], 6'(1 << idx), 8);
   endtask

   task automatic scanFrame(input logic [23:0] value);
      for (int i = 0; i < 6; i++) begin
         scanDigit(i, value[4*i +: 4]);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
      total = total + 1;
      assert (observed === expected)
      else begin
         bad = bad + 1;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      valid_count = 0;
      last_frame  = 24'h0;
      reset       = 1'b1;
      seg_in      = BLANK;
      digit_sel   = 6'd0;
      frame_ready = 1'b0;
      err_clr     = 1'b0;

      // Reset state.
      waitCycles(2);
      checkOutput("rst_frame_value", frame_value, 24'h000000);
      checkOutput("rst_frame_valid", {23'd0, frame_valid}, 24'd0);
      checkOutput("rst_digit_valid", {18'd0, digit_valid}, 24'd0);
      checkOutput("rst_overrun", {23'd0, overrun}, 24'd0);
      checkOutput("rst_err_illegal", {23'd0, err_illegal}, 24'd0);
      reset = 1'b0;
      waitCycles(1);

      // Scan 0x3A7F1C with frame_ready high. Digit 5 is stepped one cycle at
      // a time to check the one-cycle load latency and the one-cycle pulse.
      $display("[TB] scan 0x3A7F1C");
      frame_ready = 1'b1;
      valid_count = 0;
      scanDigit(0, 4'hC);
      scanDigit(1, 4'h1);
      scanDigit(2, 4'hF);
      scanDigit(3, 4'h7);
      scanDigit(4, 4'hA);
      applyStimulus(GLYPH[3], 6'b100000, 4);
      checkOutput("lat_capture_edge", {23'd0, frame_valid}, 24'd0);
      waitCycles(1);
      checkOutput("lat_next_edge", {23'd0, frame_valid}, 24'd1);
      checkOutput("frame1_value", frame_value, 24'h3A7F1C);
      checkOutput("frame1_digit_valid", {18'd0, digit_valid}, 24'h3F);
      waitCycles(1);
      checkOutput("frame1_accepted", {23'd0, frame_valid}, 24'd0);
      waitCycles(2);
      checkOutput("frame1_pulse_len", 24'(valid_count), 24'd1);

      // Glitch: a blank on digit 2 for only 3 cycles must not capture. The
      // frame then stays incomplete until digit 2 really settles.
      $display("[TB] glitch on digit 2");
      valid_count = 0;
      applyStimulus(BLANK, 6'b000100, 3);
      applyStimulus(BLANK, 6'b000000, 2);
      checkOutput("glitch_digit_valid", {18'd0, digit_valid}, 24'h3F);
      scanDigit(0, 4'hC);
      scanDigit(1, 4'h1);
      scanDigit(3, 4'h7);
      scanDigit(4, 4'hA);
      scanDigit(5, 4'h3);
      checkOutput("glitch_no_frame", 24'(valid_count), 24'd0);
      scanDigit(2, 4'h5);
      checkOutput("glitch_frame_count", 24'(valid_count), 24'd1);
      checkOutput("glitch_frame_value", last_frame, 24'h3A751C);

      // Two strobe bits together for 10 cycles: no capture.
      $display("[TB] multi-bit strobe");
      applyStimulus(BLANK, 6'b000011, 10);
      checkOutput("multi_digit_valid", {18'd0, digit_valid}, 24'h3F);
      checkOutput("multi_frame_count", 24'(valid_count), 24'd1);

      // Overrun: two frames with frame_ready low. Digit 0 is captured twice,
      // so the repeat updates the nibble without completing the frame.
      $display("[TB] overrun");
      frame_ready = 1'b0;
      scanDigit(0, 4'h9);
      scanDigit(1, 4'h2);
      scanDigit(2, 4'h3);
      scanDigit(3, 4'h4);
      scanDigit(4, 4'h5);
      scanDigit(0, 4'h1);
      checkOutput("repeat_no_frame", {23'd0, frame_valid}, 24'd0);
      scanDigit(5, 4'h6);
      checkOutput("ovr_frame_a_value", frame_value, 24'h654321);
      checkOutput("ovr_frame_a_valid", {23'd0, frame_valid}, 24'd1);
      checkOutput("ovr_before", {23'd0, overrun}, 24'd0);
      scanFrame(24'hFEDCBA);
      checkOutput("ovr_frame_b_value", frame_value, 24'hFEDCBA);
      checkOutput("ovr_frame_b_valid", {23'd0, frame_valid}, 24'd1);
      checkOutput("ovr_set", {23'd0, overrun}, {23'd0, ERR_EN});
      err_clr = 1'b1;
      waitCycles(1);
      err_clr = 1'b0;
      checkOutput("ovr_cleared", {23'd0, overrun}, 24'd0);
      frame_ready = 1'b1;
      waitCycles(1);
      checkOutput("ovr_accepted", {23'd0, frame_valid}, 24'd0);

      // Illegal digit 4 and blank digit 5. The frame still completes, and
      // nibbles 4 and 5 keep their old working values (E and F).
      $display("[TB] illegal and blank digits");
      valid_count = 0;
      scanDigit(0, 4'h3);
      scanDigit(1, 4'h2);
      scanDigit(2, 4'h1);
      scanDigit(3, 4'h0);
      applyStimulus(ILLEGAL, 6'b010000, 8);
      applyStimulus(BLANK, 6'b100000, 8);
      checkOutput("ill_digit_valid", {18'd0, digit_valid}, 24'h0F);
      checkOutput("ill_err_illegal", {23'd0, err_illegal}, {23'd0, ERR_EN});
      checkOutput("ill_frame_count", 24'(valid_count), 24'd1);
      checkOutput("ill_frame_value", last_frame, 24'hFE0123);
      checkOutput("ill_no_overrun", {23'd0, overrun}, 24'd0);
      err_clr = 1'b1;
      waitCycles(1);
      err_clr = 1'b0;
      checkOutput("ill_err_cleared", {23'd0, err_illegal}, 24'd0);

      // Reset after three captures, partway through a fourth digit.
      $display("[TB] reset mid-frame");
      scanDigit(0, 4'h9);
      scanDigit(1, 4'h9);
      scanDigit(2, 4'h9);
      applyStimulus(GLYPH[8], 6'b001000, 2);
      reset = 1'b1;
      #1;
      checkOutput("midrst_frame_value", frame_value, 24'h000000);
      checkOutput("midrst_digit_valid", {18'd0, digit_valid}, 24'd0);
      checkOutput("midrst_frame_valid", {23'd0, frame_valid}, 24'd0);
      waitCycles(1);
      reset = 1'b0;
      valid_count = 0;
      scanFrame(24'h000123);
      checkOutput("postrst_frame_count", 24'(valid_count), 24'd1);
      checkOutput("postrst_frame_value", last_frame, 24'h000123);
      checkOutput("postrst_digit_valid", {18'd0, digit_valid}, 24'h3F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
